fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that generalises the single-register program counter into a PC generator plus a DEPTH-entry prefetch queue. It drives the instruction memory address every cycle, captures {pc, instruction} pairs into a FIFO, and hands them to decode through a valid/ready handshake. A branch/jump redirect flushes the queue and reloads the PC. It sits between the instruction memory and the control/decode stage.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (≥2)
- RESET_VEC, 0, PC value after reset
- INSTR_BYTES, 4, PC increment per instruction (power of two)

Ports:
- Clk  in  1  clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  ADDR_W  address presented to instruction memory, = fetch_pc
- imem_en  out  1  fetch enable to instruction memory
- imem_rdata  in  DATA_W  instruction at imem_addr, combinational same-cycle read
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  ADDR_W  new PC on redirect
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_pc  out  ADDR_W  PC of head entry
- out_instr  out  DATA_W  instruction of head entry
- count  out  $clog2(DEPTH+1)  current occupancy
- align_err  out  1  sticky misaligned-redirect flag

## Operation
- Reset values: fetch_pc=RESET_VEC, count=0, read/write pointers=0, align_err=0; out_valid=0, imem_en=1 on release.
- push = imem_en & ~redirect_valid & (count<DEPTH | pop); entry written = {fetch_pc, imem_rdata}; fetch_pc += INSTR_BYTES, wraps modulo 2^ADDR_W.
- pop = out_valid & out_ready; advances read pointer.
- out_valid = (count≠0) & ~redirect_valid; out_pc/out_instr = head entry (combinational from storage; X-free when count=0: hold last head).
- imem_en = (count<DEPTH | out_ready) & ~align_err.
- Redirect (priority over push and pop): count←0, pointers←0, fetch_pc←redirect_target; no entry written that cycle; any handshake that cycle is void.
- Full with pop: push and pop both happen, count unchanged.
- Empty with push: entry becomes visible next cycle (no bypass).
- Pointers wrap at DEPTH (DEPTH need not be a power of two).

## Timing
- Fetch-to-decode latency: 1 cycle (written at edge N, out_valid in cycle N+1).
- Redirect-to-first-valid: 2 cycles (edge R loads PC, edge R+1 writes first entry, out_valid from R+1).
- Throughput: one instruction per cycle sustained when out_ready=1.
- Reset asserted mid-operation: all state cleared immediately (asynchronous); queued entries lost; fetch restarts at RESET_VEC on first edge after release.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_target with low log2(INSTR_BYTES) bits ≠0 sets align_err (sticky), loads fetch_pc with target masked to alignment, and stops fetching (imem_en=0, no pushes). Only a subsequent aligned redirect or Reset clears align_err and resumes fetch. Simultaneous aligned redirect while align_err=1 clears it that edge.
- Undefined: align_err tied 0; redirect_target low bits silently masked; fetch never halts on alignment.

## Test plan
- Reset release, out_ready=1, memory word at address k = k: out_pc sequence 0,4,8,12…, out_instr matching, out_valid from cycle 1 on, one per cycle.
- out_ready=0 for 10 cycles (DEPTH=4): count saturates at 4, imem_en=0, fetch_pc=16; raise out_ready: entries 0,4,8,12 then 16 pop in order, no loss or duplicate.
- Redirect to 0x100 with count=3: out_valid=0 in redirect cycle, count=0 next cycle, first out_pc=0x100 two cycles after redirect, stale entries never appear.
- RESET_VEC=0xFFFF_FFF8, ADDR_W=32: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- With FETCH_ALIGN_CHECK_EN: redirect to 0x102 → align_err=1, fetch_pc=0x100, no pushes; redirect to 0x200 → align_err=0, out_pc=0x200 follows. Without macro: redirect to 0x102 → out_pc=0x100, align_err stays 0.
- Reset asserted asynchronously mid-burst with count=2: count, out_valid drop to 0 before next edge; after release first out_pc=RESET_VEC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry prefetch queue toward decode.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise sticky align_err and halt fetch.
module fetch_queue #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       DEPTH       = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int unsigned       INSTR_BYTES = 4
) (
   input  logic                         Clk,
   input  logic                         Reset,
   output logic [ADDR_W-1:0]            imem_addr,
   output logic                         imem_en,
   input  logic [DATA_W-1:0]            imem_rdata,
   input  logic                         redirect_valid,
   input  logic [ADDR_W-1:0]            redirect_target,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_pc,
   output logic [DATA_W-1:0]            out_instr,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         align_err
);

   localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
   localparam int unsigned       PTR_W      = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));
   localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(DEPTH - 1);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } entry_t;

   entry_t            q_mem [DEPTH];
   logic [ADDR_W-1:0] fetch_pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              not_full;
   logic              push;
   logic              pop;

   // Handshake and fetch-enable decode; redirect voids any same-cycle handshake
   always_comb begin
      not_full  = (count != CNT_W'(DEPTH));
      imem_en   = (not_full | out_ready) & ~align_err;
      out_valid = (count != '0) & ~redirect_valid;
      pop       = out_valid & out_ready;
      push      = imem_en & ~redirect_valid & (not_full | pop);
   end

   assign imem_addr = fetch_pc;
   assign out_pc    = q_mem[rd_ptr].pc;
   assign out_instr = q_mem[rd_ptr].instr;

   // PC, pointers and occupancy; redirect outranks push and pop
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fetch_pc <= RESET_VEC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_target & ALIGN_MASK;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
            wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry storage is cleared on reset so the head never reads X
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_mem[i] <= '0;
         end
      end else if (push) begin
         q_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic redirect_aligned;

   assign redirect_aligned = ~|(redirect_target & ~ALIGN_MASK);

   // Sticky until an aligned redirect or reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         align_err <= 1'b0;
      end else if (redirect_valid) begin
         align_err <= ~redirect_aligned;
      end
   end
`else
   assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: streaming, backpressure, redirect,
// PC wrap, alignment handling and asynchronous reset.
module tb_fetch_queue;

   logic        Clk;
   logic        Reset;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;
   logic        align_err;

   logic [31:0] w_imem_addr;
   logic        w_imem_en;
   logic [31:0] w_imem_rdata;
   logic        w_out_valid;
   logic [31:0] w_out_pc;
   logic [31:0] w_out_instr;
   logic [2:0]  w_count;
   logic        w_align_err;

   int total;
   int bad;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_rdata   = mem_word(imem_addr);
   assign w_imem_rdata = mem_word(w_imem_addr);

   fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_VEC(32'h0), .INSTR_BYTES(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .count(count), .align_err(align_err)
   );

   fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_VEC(32'hFFFF_FFF8), .INSTR_BYTES(4)) dut_w (
      .Clk(Clk), .Reset(Reset),
      .imem_addr(w_imem_addr), .imem_en(w_imem_en), .imem_rdata(w_imem_rdata),
      .redirect_valid(1'b0), .redirect_target(32'h0),
      .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc), .out_instr(w_out_instr),
      .count(w_count), .align_err(w_align_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic apply_reset(input logic rdy);
      @(negedge Clk);
      Reset          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = rdy;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
   endtask

   task automatic next_cycle();
      @(negedge Clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset(1'b1);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL reset_imem_en got=%b exp=1", imem_en); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      total++; if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align got=%b exp=0", align_err); end
   endtask

   task automatic test_stream();
      apply_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
         total++; if (out_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(4 * i)); end
         total++; if (out_instr !== mem_word(32'(4 * i))) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, mem_word(32'(4 * i))); end
         total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
      end
   endtask

   task automatic test_backpressure();
      apply_reset(1'b0);
      for (int i = 0; i < 10; i++) next_cycle();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", count); end
      total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL bp_imem_en got=%b exp=0", imem_en); end
      total++; if (imem_addr !== 32'd16) begin bad++; $display("FAIL bp_fetch_pc got=%h exp=10", imem_addr); end
      total++; if (out_pc !== 32'd0) begin bad++; $display("FAIL bp_head got=%h exp=0", out_pc); end
      @(negedge Clk);
      out_ready = 1'b1;
      #1;
      total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL bp_en_ready got=%b exp=1", imem_en); end
      for (int i = 0; i < 6; i++) begin
         total++; if (out_pc !== 32'(4 * i) || out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_drain_pc[%0d] got=%h/%b exp=%h/1", i, out_pc, out_valid, 32'(4 * i));
         end
         total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_drain_count[%0d] got=%0d exp=4", i, count); end
         next_cycle();
      end
   endtask

   task automatic test_redirect();
      apply_reset(1'b0);
      for (int i = 0; i < 3; i++) next_cycle();
      total++; if (count !== 3'd3) begin bad++; $display("FAIL rd_pre_count got=%0d exp=3", count); end
      @(negedge Clk);
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      out_ready       = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_in_cycle got=%b exp=0", out_valid); end
      @(negedge Clk);
      redirect_valid = 1'b0;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rd_count got=%0d exp=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_after got=%b exp=0", out_valid); end
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL rd_fetch_pc got=%h exp=100", imem_addr); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i)) begin
            bad++; $display("FAIL rd_seq[%0d] got=%h/%b exp=%h/1", i, out_pc, out_valid, 32'h100 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_wrap();
      apply_reset(1'b1);
      total++; if (w_out_valid !== 1'b0) begin bad++; $display("FAIL wrap_reset_valid got=%b exp=0", w_out_valid); end
      next_cycle();
      total++; if (w_out_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", w_out_pc); end
      next_cycle();
      total++; if (w_out_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", w_out_pc); end
      next_cycle();
      total++; if (w_out_pc !== 32'h0 || w_out_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc2 got=%h/%b exp=0/1", w_out_pc, w_out_valid); end
      total++; if (w_out_instr !== mem_word(32'h0)) begin bad++; $display("FAIL wrap_instr2 got=%h exp=%h", w_out_instr, mem_word(32'h0)); end
   endtask

   task automatic test_align();
      apply_reset(1'b1);
      @(negedge Clk);
      redirect_valid  = 1'b1;
      redirect_target = 32'h102;
      @(negedge Clk);
      redirect_valid = 1'b0;
      #1;
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL al_fetch_pc got=%h exp=100", imem_addr); end
`ifdef FETCH_ALIGN_CHECK_EN
      total++; if (align_err !== 1'b1) begin bad++; $display("FAIL al_err_set got=%b exp=1", align_err); end
      total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL al_en_off got=%b exp=0", imem_en); end
      next_cycle();
      next_cycle();
      total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL al_no_push got=%0d/%b exp=0/0", count, out_valid); end
      total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL al_pc_hold got=%h exp=100", imem_addr); end
      @(negedge Clk);
      redirect_valid  = 1'b1;
      redirect_target = 32'h200;
      @(negedge Clk);
      redirect_valid = 1'b0;
      #1;
      total++; if (align_err !== 1'b0 || imem_en !== 1'b1) begin bad++; $display("FAIL al_err_clear got=%b/%b exp=0/1", align_err, imem_en); end
      next_cycle();
      total++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin bad++; $display("FAIL al_resume got=%h/%b exp=200/1", out_pc, out_valid); end
`else
      total++; if (align_err !== 1'b0) begin bad++; $display("FAIL al_err_tied got=%b exp=0", align_err); end
      next_cycle();
      total++; if (out_pc !== 32'h100 || out_valid !== 1'b1) begin bad++; $display("FAIL al_masked got=%h/%b exp=100/1", out_pc, out_valid); end
      total++; if (align_err !== 1'b0) begin bad++; $display("FAIL al_err_stays got=%b exp=0", align_err); end
`endif
   endtask

   task automatic test_async_reset();
      apply_reset(1'b0);
      @(posedge Clk);
      @(posedge Clk);
      #2;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL ar_pre_count got=%0d exp=2", count); end
      Reset = 1'b1;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d exp=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
      @(negedge Clk);
      Reset     = 1'b0;
      out_ready = 1'b1;
      #1;
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL ar_fetch_pc got=%h exp=0", imem_addr); end
      next_cycle();
      total++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin bad++; $display("FAIL ar_first got=%h/%b exp=0/1", out_pc, out_valid); end
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      Reset           = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      out_ready       = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_align();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
